vx_issue_warp_arbiter: RTL



---
 rtl/vx_issue_warp_arbiter_pkg.sv | 14 +
 rtl/vx_issue_warp_arbiter_if.sv | 29 ++
 rtl/VX_rr_picker.sv | 30 +++
 rtl/vx_issue_warp_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/vx_issue_warp_arbiter_pkg.sv
// Shared issue-stage definitions for the warp arbiter slice.
// Holds warp counts, the store-lag default and the arbiter state type.
package vx_issue_warp_arbiter_pkg;

    localparam int PER_ISSUE_WARPS = 4;
    localparam int ISSUE_WIS_W     = $clog2(PER_ISSUE_WARPS);
    localparam int ISSUE_STORE_LAG = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } issue_arb_state_e;

endpackage

// File: rtl/vx_issue_warp_arbiter_if.sv
// Request/grant bundle between the per-warp ibuffers, the arbiter and
// the operand-collection stage.
interface vx_issue_warp_arbiter_if #(
    parameter int N = 4,
    parameter int W = $clog2(N)
);
    logic [N-1:0] req_valid;
    logic [N-1:0] req_sop;
    logic [N-1:0] req_eop;
    logic [N-1:0] req_fence;
    logic [N-1:0] req_store;
    logic [N-1:0] req_ready;
    logic         out_valid;
    logic [W-1:0] out_wis;
    logic         out_ready;

    modport master (
        output req_valid, req_sop, req_eop, req_fence, req_store,
        output out_ready,
        input  req_ready, out_valid, out_wis
    );

    modport slave (
        input  req_valid, req_sop, req_eop, req_fence, req_store,
        input  out_ready,
        output req_ready, out_valid, out_wis
    );

endinterface

// File: rtl/VX_rr_picker.sv
// Round-robin priority picker: first set bit of valid at or after start,
// wrapping modulo N.
module VX_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] start,
    output logic [N-1:0] onehot,
    output logic [W-1:0] index,
    output logic         any
);

    always_comb begin
        logic [W-1:0] jj;
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        jj     = '0;
        for (int k = 0; k < N; k++) begin
            jj = W'((int'(start) + k) % N);
            if (!any && valid[jj]) begin
                any        = 1'b1;
                index      = jj;
                onehot[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_issue_warp_arbiter.sv
// Issue-slice warp arbiter: round-robin pick, multi-packet lock,
// fence gating behind store drain plus a short store-lag window.
module vx_issue_warp_arbiter
    import vx_issue_warp_arbiter_pkg::*;
#(
    parameter int NUM_REQS      = PER_ISSUE_WARPS,
    parameter int STORE_LAG     = ISSUE_STORE_LAG,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     no_pending_stores,
    vx_issue_warp_arbiter_if.slave   arb,
    output logic [PERF_CTR_BITS-1:0] perf_stalls
);

    localparam int WIS_W = $clog2(NUM_REQS);
    localparam int LAG_W = $clog2(STORE_LAG + 2);

    issue_arb_state_e    state;
    logic [WIS_W-1:0]    rr_ptr;
    logic [WIS_W-1:0]    lock_wis;
    logic [LAG_W-1:0]    lag_cnt;

    logic                fence_block;
    logic [NUM_REQS-1:0] elig;
    logic [NUM_REQS-1:0] cand;
    logic [NUM_REQS-1:0] sel_oh;
    logic [WIS_W-1:0]    sel;
    logic                sel_any;
    logic                out_valid;
    logic                fire;
    logic                sel_sop;
    logic                sel_eop;
    logic                sel_store;

    // Fences wait for the drain flag and for the lag window, which
    // covers stores granted before the flag has caught up.
    assign fence_block = !no_pending_stores || (lag_cnt != '0);

    always_comb begin
        elig = arb.req_valid
             & ~(arb.req_fence & arb.req_sop & {NUM_REQS{fence_block}});
        cand = elig;
        if (state == LOCKED)
            cand = elig & (NUM_REQS'(1) << lock_wis);
    end

    VX_rr_picker #(
        .N (NUM_REQS),
        .W (WIS_W)
    ) picker (
        .valid  (cand),
        .start  (rr_ptr),
        .onehot (sel_oh),
        .index  (sel),
        .any    (sel_any)
    );

    assign out_valid = sel_any && !reset;
    assign fire      = out_valid && arb.out_ready;
    assign sel_sop   = arb.req_sop[sel];
    assign sel_eop   = arb.req_eop[sel];
    assign sel_store = arb.req_store[sel];

    assign arb.out_valid = out_valid;
    assign arb.out_wis   = sel;
    assign arb.req_ready = sel_oh & {NUM_REQS{fire}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            lock_wis    <= '0;
            lag_cnt     <= '0;
            perf_stalls <= '0;
        end else begin
            if (|arb.req_valid && !out_valid)
                perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);

            if (fire && sel_store && sel_sop)
                lag_cnt <= LAG_W'(STORE_LAG);
            else if (lag_cnt != '0)
                lag_cnt <= lag_cnt - LAG_W'(1);

            if (fire) begin
                if (sel_eop)
                    rr_ptr <= (sel == WIS_W'(NUM_REQS - 1))
                            ? '0 : sel + WIS_W'(1);
                unique case (state)
                    IDLE: begin
                        if (sel_sop && !sel_eop) begin
                            state    <= LOCKED;
                            lock_wis <= sel;
                        end
                    end
                    LOCKED: begin
                        if (sel_eop)
                            state <= IDLE;
                    end
                endcase
            end
        end
    end

    a_ready_onehot: assert property (
        @(posedge clk) disable iff (reset)
        $onehot0(arb.req_ready));

    a_locked_owner: assert property (
        @(posedge clk) disable iff (reset)
        (state == LOCKED && arb.out_valid) |-> (arb.out_wis == lock_wis));

endmodule
